// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: sequential fetch front end with credit-limited requests, redirect flush and a DEPTH-entry FIFO.
// Optional FETCH_PERF_EN adds perf_fetched/perf_dropped counters.
module instr_fetch_queue #(
  parameter int PC_WIDTH = 32,
  parameter int INSTR_WIDTH = 32,
  parameter int DEPTH = 4,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   fetch_en,
  output logic                   mem_req_valid,
  input  logic                   mem_req_ready,
  output logic [PC_WIDTH-1:0]    mem_req_addr,
  input  logic                   mem_rsp_valid,
  input  logic [INSTR_WIDTH-1:0] mem_rsp_data,
  input  logic                   redirect_valid,
  input  logic [PC_WIDTH-1:0]    redirect_pc,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic [PC_WIDTH-1:0]    instr_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]            perf_fetched,
  output logic [31:0]            perf_dropped
`endif
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
  state_t state, state_next;
  logic [PC_WIDTH-1:0] fetch_pc, rsp_pc, target_pc;
  logic [CW-1:0] outstanding, drop_cnt, drop_next, count;
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [INSTR_WIDTH-1:0] mem_i [DEPTH];
  logic [PC_WIDTH-1:0] mem_pc [DEPTH];
  logic req_fire, push, pop, unused_bits;
  // Credits: in-flight plus buffered never exceed DEPTH, so responses always find a slot.
  assign mem_req_valid = state != IDLE && fetch_en && ({1'b0, outstanding} + {1'b0, count} < (CW+1)'(DEPTH));
  assign mem_req_addr = fetch_pc;
  assign req_fire = mem_req_valid && mem_req_ready;
  assign push = mem_rsp_valid && drop_cnt == '0 && !redirect_valid;
  assign pop = instr_valid && instr_ready && !redirect_valid;
  assign instr_valid = count != '0;
  assign instr = mem_i[rd_ptr];
  assign instr_pc = mem_pc[rd_ptr];
  assign target_pc = {redirect_pc[PC_WIDTH-1:2], 2'b00};
  assign unused_bits = ^redirect_pc[1:0];
  always_comb begin
    drop_next = redirect_valid ? outstanding + CW'(req_fire) - CW'(mem_rsp_valid)
                               : drop_cnt - CW'(mem_rsp_valid && drop_cnt != '0);
    state_next = state == IDLE ? (fetch_en ? RUN : IDLE) : (drop_next != '0 ? FLUSH : RUN);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else state <= state_next;
  end
  // rsp_pc tracks the PC of the next response that will be kept, so no PC queue is needed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc <= RESET_PC;
      rsp_pc <= RESET_PC;
      outstanding <= '0;
      drop_cnt <= '0;
      count <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_i[i] <= '0;
        mem_pc[i] <= '0;
      end
    end else begin
      fetch_pc <= redirect_valid ? target_pc : req_fire ? fetch_pc + PC_WIDTH'(4) : fetch_pc;
      rsp_pc <= redirect_valid ? target_pc : push ? rsp_pc + PC_WIDTH'(4) : rsp_pc;
      outstanding <= outstanding + CW'(req_fire) - CW'(mem_rsp_valid);
      drop_cnt <= drop_next;
      count <= redirect_valid ? '0 : count + CW'(push) - CW'(pop);
      wr_ptr <= redirect_valid ? '0 : wr_ptr + AW'(push);
      rd_ptr <= redirect_valid ? '0 : rd_ptr + AW'(pop);
      if (push) begin
        mem_i[wr_ptr] <= mem_rsp_data;
        mem_pc[wr_ptr] <= rsp_pc;
      end
    end
  end
`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetched <= '0;
      perf_dropped <= '0;
    end else begin
      perf_fetched <= perf_fetched + 32'(push);
      perf_dropped <= perf_dropped + 32'(mem_rsp_valid && !push) + (redirect_valid ? 32'(count) : 32'd0);
    end
  end
`endif
endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb_instr_fetch_queue: directed table plus corner sequences against a latency-configurable in-order memory model.
module tb_instr_fetch_queue;
  logic clk = 0;
  logic rst = 0;
  logic fetch_en = 0, mem_req_ready = 1, mem_rsp_valid = 0, redirect_valid = 0, instr_ready = 1;
  logic [31:0] mem_rsp_data = 0, redirect_pc = 0;
  logic mem_req_valid, instr_valid;
  logic [31:0] mem_req_addr, instr, instr_pc;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_dropped;
`endif
  int n_run = 0, n_fail = 0, lat = 1, cyc = 0, fires;
  logic found;
  typedef struct { int due; logic [31:0] addr; } req_t;
  req_t q[$];
  typedef struct { logic fe, ir, rv; logic [31:0] rpc; logic e_rv; logic [31:0] e_addr; logic e_iv; logic [31:0] e_ipc; } vec_t;
  vec_t vecs[14];

  instr_fetch_queue dut (
    .clk(clk), .rst(rst), .fetch_en(fetch_en),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc)
`ifdef FETCH_PERF_EN
    , .perf_fetched(perf_fetched), .perf_dropped(perf_dropped)
`endif
  );

  always #5 clk = ~clk;

  // Memory: a request seen valid before edge k returns data ~addr lat cycles later, in order.
  initial forever begin
    @(negedge clk);
    cyc++;
    if (!rst) begin
      q.delete();
      mem_rsp_valid = 0;
    end else begin
      if (q.size() > 0 && q[0].due == cyc) begin
        mem_rsp_valid = 1;
        mem_rsp_data = ~q[0].addr;
        void'(q.pop_front());
      end else mem_rsp_valid = 0;
      if (mem_req_valid && mem_req_ready) q.push_back('{cyc + lat, mem_req_addr});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int l);
    rst = 0;
    lat = l;
    fetch_en = 0;
    redirect_valid = 0;
    redirect_pc = 0;
    instr_ready = 1;
    repeat (2) @(posedge clk);
    #1 rst = 1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".req_valid"}, mem_req_valid, 0);
    check({tag, ".req_addr"}, mem_req_addr, 0);
    check({tag, ".instr_valid"}, instr_valid, 0);
    check({tag, ".instr"}, instr, 0);
    check({tag, ".instr_pc"}, instr_pc, 0);
`ifdef FETCH_PERF_EN
    check({tag, ".perf_fetched"}, perf_fetched, 0);
    check({tag, ".perf_dropped"}, perf_dropped, 0);
`endif
  endtask

  initial begin
    vecs[0]  = '{1, 1, 0, 32'h0,   0, 32'h0,   0, 32'h0};
    vecs[1]  = '{1, 1, 0, 32'h0,   1, 32'h0,   0, 32'h0};
    vecs[2]  = '{1, 1, 0, 32'h0,   1, 32'h4,   0, 32'h0};
    vecs[3]  = '{1, 1, 0, 32'h0,   1, 32'h8,   1, 32'h0};
    vecs[4]  = '{1, 1, 0, 32'h0,   1, 32'hC,   1, 32'h4};
    vecs[5]  = '{1, 1, 1, 32'h103, 1, 32'h10,  1, 32'h8};
    vecs[6]  = '{1, 1, 0, 32'h0,   1, 32'h100, 0, 32'h0};
    vecs[7]  = '{1, 1, 0, 32'h0,   1, 32'h104, 0, 32'h0};
    vecs[8]  = '{1, 1, 0, 32'h0,   1, 32'h108, 1, 32'h100};
    vecs[9]  = '{1, 1, 0, 32'h0,   1, 32'h10C, 1, 32'h104};
    vecs[10] = '{0, 1, 0, 32'h0,   0, 32'h110, 1, 32'h108};
    vecs[11] = '{0, 1, 0, 32'h0,   0, 32'h110, 1, 32'h10C};
    vecs[12] = '{0, 1, 0, 32'h0,   0, 32'h110, 0, 32'h0};
    vecs[13] = '{1, 1, 0, 32'h0,   1, 32'h110, 0, 32'h0};

    rst = 0;
    lat = 1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1;

    // 1-cycle memory stream, redirect coinciding with response, pop and request, then fetch_en gating.
    foreach (vecs[i]) begin
      fetch_en = vecs[i].fe;
      instr_ready = vecs[i].ir;
      redirect_valid = vecs[i].rv;
      redirect_pc = vecs[i].rpc;
      @(negedge clk);
      check($sformatf("v%0d.req_valid", i), mem_req_valid, vecs[i].e_rv);
      check($sformatf("v%0d.req_addr", i), mem_req_addr, vecs[i].e_addr);
      check($sformatf("v%0d.instr_valid", i), instr_valid, vecs[i].e_iv);
      if (vecs[i].e_iv) begin
        check($sformatf("v%0d.instr_pc", i), instr_pc, vecs[i].e_ipc);
        check($sformatf("v%0d.instr", i), instr, ~vecs[i].e_ipc);
      end
      step();
    end
    redirect_valid = 0;
`ifdef FETCH_PERF_EN
    check("table.perf_fetched", perf_fetched, 7);
    check("table.perf_dropped", perf_dropped, 3);
`endif

    // Asynchronous reset mid-burst, then restart from RESET_PC.
    step();
    step();
    rst = 0;
    #1;
    check_reset_outputs("async_rst");
    @(posedge clk);
    #1 rst = 1;
    found = 0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge clk);
      if (mem_req_valid && mem_req_ready) begin
        found = 1;
        check("async_rst.first_addr", mem_req_addr, 0);
      end else step();
    end
    check("async_rst.first_fire_seen", found, 1);

    // Back-pressure: credits stop at DEPTH, one pop buys exactly one request.
    do_reset(1);
    fetch_en = 1;
    instr_ready = 0;
    fires = 0;
    repeat (12) begin
      @(negedge clk);
      if (mem_req_valid && mem_req_ready) fires++;
      step();
    end
    check("stall.fires", fires, 4);
    @(negedge clk);
    check("stall.req_valid", mem_req_valid, 0);
    check("stall.instr_valid", instr_valid, 1);
    check("stall.head_pc", instr_pc, 0);
    step();
    instr_ready = 1;
    fires = 0;
    @(negedge clk);
    if (mem_req_valid && mem_req_ready) fires++;
    step();
    instr_ready = 0;
    repeat (7) begin
      @(negedge clk);
      if (mem_req_valid && mem_req_ready) fires++;
      step();
    end
    check("stall.refill_fires", fires, 1);
    @(negedge clk);
    check("stall.head_pc_after_pop", instr_pc, 4);
    check("stall.req_valid_after", mem_req_valid, 0);
`ifdef FETCH_PERF_EN
    check("stall.perf_fetched", perf_fetched, 5);
    check("stall.perf_dropped", perf_dropped, 0);
`endif

    // 3-cycle memory: redirect with three requests in flight drops all three.
    do_reset(3);
    fetch_en = 1;
    instr_ready = 1;
    step();
    step();
    step();
    redirect_valid = 1;
    redirect_pc = 32'h100;
    @(negedge clk);
    check("lat3.third_req_valid", mem_req_valid, 1);
    check("lat3.third_req_addr", mem_req_addr, 32'h8);
    step();
    redirect_valid = 0;
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      if (instr_valid) found = 1;
      else step();
    end
    check("lat3.valid_seen", found, 1);
    check("lat3.first_pc", instr_pc, 32'h100);
    check("lat3.first_instr", instr, ~32'h100);
`ifdef FETCH_PERF_EN
    check("lat3.perf_fetched", perf_fetched, 1);
    check("lat3.perf_dropped", perf_dropped, 3);
`endif

    // PC wrap at the top of the address space.
    do_reset(1);
    fetch_en = 1;
    instr_ready = 1;
    repeat (4) step();
    redirect_valid = 1;
    redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_valid = 0;
    @(negedge clk);
    check("wrap.req_valid", mem_req_valid, 1);
    check("wrap.addr_top", mem_req_addr, 32'hFFFF_FFFC);
    step();
    @(negedge clk);
    check("wrap.addr_zero", mem_req_addr, 32'h0);
    step();
    found = 0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge clk);
      if (instr_valid) found = 1;
      else step();
    end
    check("wrap.valid_seen", found, 1);
    check("wrap.pc_top", instr_pc, 32'hFFFF_FFFC);
    step();
    @(negedge clk);
    check("wrap.next_valid", instr_valid, 1);
    check("wrap.pc_zero", instr_pc, 32'h0);
    check("wrap.instr_zero", instr, 32'hFFFF_FFFF);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
